// File: rtl/hazard_sequencer.sv
// IF/ID front-end pipeline control: post-reset fetch hold, load-use stall,
// taken-branch flush, external multi-cycle hold, and a saturating stall counter.
module hazard_sequencer #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       RD_EX,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic [6:0]       OPCODE_ID,
  input  logic             PCSrc,
  input  logic             ext_busy,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ctrl_bubble,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HOLD
  } state_t;

  state_t     state, state_next;
  logic [7:0] boot_cnt, boot_next;
  logic       rs1_used, rs2_used, load_use;

  // Register fields that carry no source operand must not raise a false stall.
  always_comb begin
    rs1_used = !(OPCODE_ID inside {OP_LUI, OP_AUIPC, OP_JAL});
    rs2_used = OPCODE_ID inside {OP_R, OP_S, OP_B};
    load_use = MemRead_EX && (RD_EX != 5'd0) &&
               ((rs1_used && (RS1_ID == RD_EX)) || (rs2_used && (RS2_ID == RD_EX)));
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    boot_next   = boot_cnt;
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ctrl_bubble = 1'b0;

    case (state)
      S_RUN, S_HOLD: begin
        state_next = S_RUN;
        if (state == S_HOLD && ext_busy) begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          ctrl_bubble = 1'b1;
          state_next  = S_HOLD;
        end else if (PCSrc) begin
          // Wrong-path instruction is squashed, never stalled.
          IF_ID_flush = 1'b1;
          ctrl_bubble = 1'b1;
        end else if (ext_busy) begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          ctrl_bubble = 1'b1;
          state_next  = S_HOLD;
        end else if (load_use) begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          ctrl_bubble = 1'b1;
        end
      end
      default: begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b1;
        ctrl_bubble = 1'b1;
        state_next  = S_BOOT;
        if (boot_cnt == BOOT_LAST) state_next = S_RUN;
        else                       boot_next  = boot_cnt + 8'd1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_BOOT;
      boot_cnt     <= 8'd0;
      stall_active <= 1'b0;
      stall_count  <= '0;
    end else begin
      state    <= state_next;
      boot_cnt <= boot_next;
      if (state != S_BOOT) begin
        stall_active <= !PC_write;
        if (!PC_write && (stall_count != '1))
          stall_count <= stall_count + CNT_W'(1);
      end else begin
        stall_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus random
// traffic compared against a cycle-level behavioural model of the control rules.
module tb_hazard_sequencer;

  localparam int BOOT = 4;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          MemRead_EX = 1'b0;
  logic [4:0]    RD_EX = '0, RS1_ID = '0, RS2_ID = '0;
  logic [6:0]    OPCODE_ID = 7'b0010011;
  logic          PCSrc = 1'b0, ext_busy = 1'b0;
  logic          PC_write, IF_ID_write, IF_ID_flush, ctrl_bubble, stall_active;
  logic [CW-1:0] stall_count;

  hazard_sequencer #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RD_EX(RD_EX),
    .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .OPCODE_ID(OPCODE_ID), .PCSrc(PCSrc),
    .ext_busy(ext_busy), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ctrl_bubble(ctrl_bubble),
    .stall_active(stall_active), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: frozen cycles still owed, external hold, statistics.
  int boot_left;
  bit in_hold;
  int m_cnt;
  bit m_act;
  bit e_pc, e_ifid, e_fl, e_bub;

  logic [6:0] op_pool [10] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011,
                               7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b1110011};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit hazard_now();
    bit src1, src2;
    src1 = !(OPCODE_ID == 7'b0110111 || OPCODE_ID == 7'b0010111 || OPCODE_ID == 7'b1101111);
    src2 = (OPCODE_ID == 7'b0110011 || OPCODE_ID == 7'b0100011 || OPCODE_ID == 7'b1100011);
    return MemRead_EX && RD_EX != 0 &&
           ((src1 && RS1_ID == RD_EX) || (src2 && RS2_ID == RD_EX));
  endfunction

  task automatic model_reset();
    boot_left = BOOT;
    in_hold   = 0;
    m_cnt     = 0;
    m_act     = 0;
  endtask

  task automatic predict();
    if (boot_left > 0)            {e_pc, e_ifid, e_fl, e_bub} = 4'b0011;
    else if (in_hold && ext_busy) {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
    else if (PCSrc)               {e_pc, e_ifid, e_fl, e_bub} = 4'b1111;
    else if (ext_busy)            {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
    else if (hazard_now())        {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
    else                          {e_pc, e_ifid, e_fl, e_bub} = 4'b1100;
  endtask

  task automatic advance();
    if (boot_left > 0) begin
      boot_left--;
      m_act = 0;
    end else begin
      in_hold = ext_busy && (in_hold || !PCSrc);
      m_act   = !e_pc;
      if (!e_pc && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    predict();
    check({tag, ".pc_write"},     32'(PC_write),     32'(e_pc));
    check({tag, ".if_id_write"},  32'(IF_ID_write),  32'(e_ifid));
    check({tag, ".if_id_flush"},  32'(IF_ID_flush),  32'(e_fl));
    check({tag, ".ctrl_bubble"},  32'(ctrl_bubble),  32'(e_bub));
    check({tag, ".stall_active"}, 32'(stall_active), 32'(m_act));
    check({tag, ".stall_count"},  32'(stall_count),  32'(m_cnt));
  endtask

  task automatic step(input string tag, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] op,
                      input logic pcs, input logic busy);
    @(negedge clk);
    MemRead_EX = mr; RD_EX = rd; RS1_ID = rs1; RS2_ID = rs2;
    OPCODE_ID = op; PCSrc = pcs; ext_busy = busy;
    #1;
    check_all(tag);
    advance();
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 7'b0010011, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all("in_reset");
    @(posedge clk); #2 reset = 1'b1;

    for (int i = 0; i < BOOT; i++) idle("boot");
    idle("first_run");
    check("boot_no_stalls", 32'(stall_count), 32'd0);

    // Load-use on rs2 of an R-type, then normal flow resumes.
    step("load_use_rs2", 1'b1, 5'd5, 5'd0, 5'd5, 7'b0110011, 1'b0, 1'b0);
    idle("after_load_use");
    check("one_stall_counted", 32'(stall_count), 32'd1);
    step("rd_x0", 1'b1, 5'd0, 5'd0, 5'd0, 7'b0110011, 1'b0, 1'b0);
    step("itype_rs2_only", 1'b1, 5'd5, 5'd0, 5'd5, 7'b0010011, 1'b0, 1'b0);
    step("lui_rs1_match", 1'b1, 5'd7, 5'd7, 5'd0, 7'b0110111, 1'b0, 1'b0);
    step("load_rs1", 1'b1, 5'd9, 5'd9, 5'd1, 7'b0000011, 1'b0, 1'b0);

    // Branch flush overrides both a hazard and ext_busy.
    step("flush_wins", 1'b1, 5'd5, 5'd5, 5'd5, 7'b0110011, 1'b1, 1'b1);
    idle("after_flush");

    // Three-cycle external hold.
    for (int i = 0; i < 3; i++) step("ext_hold", 1'b0, 5'd0, 5'd0, 5'd0, 7'b0010011, 1'b0, 1'b1);
    idle("hold_release");
    idle("hold_done");

    // Reset lands in the second HOLD cycle.
    step("pre_reset_hold0", 1'b0, 5'd0, 5'd0, 5'd0, 7'b0010011, 1'b0, 1'b1);
    step("pre_reset_hold1", 1'b0, 5'd0, 5'd0, 5'd0, 7'b0010011, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("mid_hold_reset");
    @(posedge clk); #2 reset = 1'b1; ext_busy = 1'b0;
    for (int i = 0; i < BOOT; i++) idle("reboot");
    idle("reboot_run");

    // Random traffic biased toward register collisions.
    for (int i = 0; i < 400; i++) begin
      step("random",
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           op_pool[$urandom_range(0, 9)],
           1'($urandom_range(0, 99) < 15),
           1'($urandom_range(0, 99) < 20));
    end

    // Long hold drives the counter into saturation.
    for (int i = 0; i < CMAX + 8; i++) step("sat_hold", 1'b0, 5'd0, 5'd0, 5'd0, 7'b0010011, 1'b0, 1'b1);
    idle("sat_release");
    check("saturated", 32'(stall_count), 32'(CMAX));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control unit for the IF/ID front end of the 5-stage RISC-V core.
- Sequences a post-reset fetch hold and detects load-use hazards.
- Applies taken-branch flushes and multi-cycle external stalls.
- Drives PC_write, IF_ID_write and the ID/EX control bubble, and keeps a saturating stall-cycle counter for debug.

Parameters:
- BOOT_CYCLES, 4, cycles PC and IF/ID stay frozen after reset release (instruction memory warm-up); legal range 1..255
- CNT_W, 16, width of the stall statistics counter

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low reset
- MemRead_EX  input  1  instruction in EX is a load
- RD_EX  input  5  destination register of the instruction in EX
- RS1_ID  input  5  rs1 field of the instruction in ID
- RS2_ID  input  5  rs2 field of the instruction in ID
- OPCODE_ID  input  7  opcode of the instruction in ID
- PCSrc  input  1  taken branch or jump resolved in EX this cycle
- ext_busy  input  1  multi-cycle unit requests a pipeline hold
- PC_write  output  1  PC register enable
- IF_ID_write  output  1  IF/ID pipeline register enable
- IF_ID_flush  output  1  load NOP (0x00000013) into IF/ID at the next edge
- ctrl_bubble  output  1  zero all ID/EX control signals this cycle
- stall_active  output  1  registered: previous cycle was a stall of any kind
- stall_count  output  CNT_W  saturating count of stalled cycles since reset

Behaviour:
- Reset (reset=0, asynchronous):
  - state=BOOT, boot counter=0, stall_active=0, stall_count=0.
  - Combinational outputs while in reset: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ctrl_bubble=1.
- States:
  - BOOT:
    - PC_write=0, IF_ID_write=0, IF_ID_flush=1, ctrl_bubble=1.
    - Counter increments each cycle; on reaching BOOT_CYCLES-1, go to RUN. So exactly BOOT_CYCLES frozen cycles after reset deasserts.
    - Inputs are ignored.
  - RUN:
    - Outputs are combinational (Mealy), evaluated in the priority order below.
    - Default: PC_write=1, IF_ID_write=1, IF_ID_flush=0, ctrl_bubble=0.
  - HOLD:
    - Entered when ext_busy=1 in RUN with PCSrc=0.
    - PC_write=0, IF_ID_write=0, ctrl_bubble=1, IF_ID_flush=0.
    - Stays while ext_busy=1; first cycle with ext_busy=0 behaves as RUN and returns to RUN.
- RUN priority, highest first:
  1. PCSrc=1: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ctrl_bubble=1. Stay in RUN. Overrides a load-use hazard and ext_busy in the same cycle, so the wrong-path instruction is never stalled.
  2. ext_busy=1: HOLD outputs this cycle; next state HOLD.
  3. Load-use hazard: PC_write=0, IF_ID_write=0, ctrl_bubble=1, IF_ID_flush=0. Stay in RUN.
     - Exactly one bubble per hazard, since the load advances to MEM next cycle.
- Load-use hazard condition:
  - MemRead_EX=1 and RD_EX!=0, and either:
    - RS1_ID==RD_EX with rs1 used, or
    - RS2_ID==RD_EX with rs2 used.
  - rs1 is used for every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is used only for R 0110011, S 0100011 and B 1100011.
  - x0 never creates a hazard.
- Statistics:
  - stall_active <= (PC_write==0) at each edge, excluding BOOT.
  - stall_count increments on the same condition and saturates at all-ones with no wrap.
  - Flush cycles are not counted as stalls.
- Reset mid-HOLD or mid-stall: immediate return to BOOT with all counters cleared. BOOT always runs its full length again.

Test Plan:
- Reset release with BOOT_CYCLES=4 -> PC_write=0 and IF_ID_flush=1 for exactly 4 cycles; PC_write=1 on cycle 5; stall_count=0.
- RUN, MemRead_EX=1, RD_EX=5, OPCODE_ID=0110011, RS2_ID=5 -> one cycle with PC_write=0, IF_ID_write=0, ctrl_bubble=1; next cycle MemRead_EX=0 gives normal flow; stall_count=1.
- Same stimulus with RD_EX=0, or OPCODE_ID=0010011 (I-type) with only RS2_ID matching -> no stall.
- PCSrc=1 concurrent with a load-use hazard and ext_busy=1 -> IF_ID_flush=1, ctrl_bubble=1, PC_write=1; state stays RUN; stall_count unchanged.
- ext_busy high for 3 cycles -> PC_write=0 for 3 cycles, resumes the cycle ext_busy drops; stall_count+=3; stall_active tracks one cycle late.
- reset asserted during the second HOLD cycle -> outputs go to reset values immediately; after release, a full BOOT_CYCLES sequence with stall_count=0.
